// File: rtl/alu_32_bit_if.sv
// Operand, select and result bundle for the 32-bit execute ALU.
// The master drives operands and select bits. The slave returns F and Co.
interface alu_32_bit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        S0;
    logic        S1;
    logic        S2;
    logic        Ci;
    logic [31:0] F;
    logic        Co;

    modport master (
        output a, b, S0, S1, S2, Ci,
        input  F, Co
    );

    modport slave (
        input  a, b, S0, S1, S2, Ci,
        output F, Co
    );
endinterface

// File: rtl/alu_32_bit.sv
// 32-bit registered ALU: ripple-carry arithmetic unit with B conditioning
// (S2=0) or bitwise logic unit (S2=1). Results appear one edge after sampling.
module alu_32_bit (
    input  logic         clk,
    input  logic         rst,
    alu_32_bit_if.slave  bus
);
    localparam int unsigned WIDTH = 32;

    logic [WIDTH-1:0] y_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] logic_c;
    logic             co_c;
    logic             carry;

    // B-side conditioning for the adder
    always_comb begin
        y_c = '0;
        unique case ({bus.S1, bus.S0})
            2'b00:   y_c = '0;
            2'b01:   y_c = bus.b;
            2'b10:   y_c = ~bus.b;
            default: y_c = '1;
        endcase
    end

    // Chain of full adders, LSB first, carry threaded through a variable
    always_comb begin
        sum_c = '0;
        carry = bus.Ci;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_c[i] = bus.a[i] ^ y_c[i] ^ carry;
            carry    = (bus.a[i] & y_c[i]) | (carry & (bus.a[i] ^ y_c[i]));
        end
        co_c = carry;
    end

    always_comb begin
        logic_c = '0;
        unique case ({bus.S1, bus.S0})
            2'b00:   logic_c = bus.a & bus.b;
            2'b01:   logic_c = bus.a | bus.b;
            2'b10:   logic_c = bus.a ^ bus.b;
            default: logic_c = ~bus.a;
        endcase
    end

    // Output registers. The logic unit never produces a carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.F  <= '0;
            bus.Co <= 1'b0;
        end else if (bus.S2) begin
            bus.F  <= logic_c;
            bus.Co <= 1'b0;
        end else begin
            bus.F  <= sum_c;
            bus.Co <= co_c;
        end
    end
endmodule

// File: tb/tb_alu_32_bit.sv
// Directed, table-driven bench for alu_32_bit, with hand sequences for
// reset behaviour and between-edge input changes.
module tb_alu_32_bit;
    logic clk;
    logic rst;

    alu_32_bit_if bus ();

    alu_32_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        ci;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_f;
        logic        exp_co;
    } vec_t;

    vec_t vecs[$];
    int   tests_run;
    int   tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic [2:0] sel, input logic ci, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] f, input logic co);
        vec_t v;
        v.sel = sel; v.ci = ci; v.a = a; v.b = b; v.exp_f = f; v.exp_co = co;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] sel, input logic ci, input logic [31:0] a,
                         input logic [31:0] b);
        bus.S2 = sel[2];
        bus.S1 = sel[1];
        bus.S0 = sel[0];
        bus.Ci = ci;
        bus.a  = a;
        bus.b  = b;
    endtask

    task automatic check(input string name, input logic [31:0] f, input logic co);
        tests_run++;
        if (bus.F !== f || bus.Co !== co) begin
            tests_failed++;
            $display("FAIL %s: got F=%08h Co=%b, expected F=%08h Co=%b",
                     name, bus.F, bus.Co, f, co);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        drive(3'b000, 1'b0, 32'h0, 32'h0);

        // arithmetic
        add_vec(3'b010, 1'b1, 32'h81010101, 32'h61616161, 32'h1F9F9FA0, 1'b1);
        add_vec(3'b010, 1'b1, 32'hA5010127, 32'h61616167, 32'h439F9FC0, 1'b1);
        add_vec(3'b010, 1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        add_vec(3'b010, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1);
        add_vec(3'b010, 1'b0, 32'h0000000A, 32'h00000003, 32'h00000006, 1'b1);
        add_vec(3'b001, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        add_vec(3'b001, 1'b1, 32'h00000005, 32'h00000003, 32'h00000009, 1'b0);
        add_vec(3'b001, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0);
        add_vec(3'b000, 1'b1, 32'h0000000F, 32'hDEADBEEF, 32'h00000010, 1'b0);
        add_vec(3'b000, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1);
        add_vec(3'b000, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        add_vec(3'b011, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        add_vec(3'b011, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1);
        add_vec(3'b011, 1'b0, 32'h00000005, 32'h00000000, 32'h00000004, 1'b1);
        // logic unit: Ci ignored, Co always 0
        add_vec(3'b100, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        add_vec(3'b101, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        add_vec(3'b110, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        add_vec(3'b111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0);
        add_vec(3'b100, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        add_vec(3'b101, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);

        // asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1 check("reset_initial", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].ci, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1 check($sformatf("vec%0d_sel%03b", i, vecs[i].sel), vecs[i].exp_f, vecs[i].exp_co);
        end

        // input changes between edges do not reach the outputs
        @(negedge clk);
        drive(3'b001, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        @(posedge clk);
        #1 check("hold_load", 32'h00000000, 1'b1);
        @(negedge clk);
        drive(3'b111, 1'b0, 32'h00000000, 32'h00000000);
        #1 check("hold_between_edges", 32'h00000000, 1'b1);
        @(posedge clk);
        #1 check("hold_next_edge", 32'hFFFFFFFF, 1'b0);

        // reset asserted between edges clears outputs immediately and holds them
        @(negedge clk);
        drive(3'b001, 1'b1, 32'h00000005, 32'h00000003);
        #2 rst = 1'b1;
        #1 check("reset_async", 32'h0, 1'b0);
        @(posedge clk);
        #1 check("reset_hold_edge1", 32'h0, 1'b0);
        @(posedge clk);
        #1 check("reset_hold_edge2", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_no_edge", 32'h0, 1'b0);
        @(posedge clk);
        #1 check("reset_first_result", 32'h00000009, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
